// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin Wishbone arbiter for I-cache (port 0) and D-cache (port 1) with locked bursts and ack watchdog
module mem_bus_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i,
    output logic [1:0]  grant_o
);
    localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2, HOLD = 2'd3;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d, last_q, last_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   adr_q, adr_d, dat_q, dat_d, rd0_q, rd0_d, rd1_q, rd1_d;
    logic          we_q, we_d, cyc_q, cyc_d, stb_q, stb_d;
    logic [3:0]    sel_q, sel_d;
    logic [1:0]    grant_q, grant_d, ack_q, ack_d, err_q, err_d;
    logic          pick, own_req, own_lock, take, in_bus, hit, tmo;

    // Decide who gets the bus next, whether a beat is latched, and how the current beat ends
    always_comb begin
        pick     = (state_q == HOLD) ? owner_q : ((m0_req & m1_req) ? ~last_q : m1_req);
        own_req  = owner_q ? m1_req : m0_req;
        own_lock = owner_q ? m1_lock : m0_lock;
        take     = ((state_q == IDLE) & (m0_req | m1_req)) | ((state_q == HOLD) & own_req);
        in_bus   = state_q == BUS;
        hit      = in_bus & wb_ack_i;
        tmo      = in_bus & ~wb_ack_i & (TIMEOUT != 0) & (timer_q == TLAST);
    end

    // Next-state values; beat fields are captured only at grant so the bus never sees requester glitches
    always_comb begin
        state_d = (state_q == IDLE) ? (take ? BUS : IDLE) :
                  (state_q == BUS)  ? ((hit | tmo) ? RESP : BUS) :
                  (state_q == RESP) ? (((|ack_q) & own_lock) ? HOLD : IDLE) :
                  (own_req ? BUS : (own_lock ? HOLD : IDLE));
        owner_d = take ? pick : owner_q;
        last_d  = take ? pick : last_q;
        timer_d = take ? '0 : (in_bus ? timer_q + 1'b1 : timer_q);
        adr_d   = take ? (pick ? m1_addr : m0_addr) : adr_q;
        dat_d   = take ? (pick ? m1_wdata : m0_wdata) : dat_q;
        we_d    = take ? (pick ? m1_we : m0_we) : we_q;
        sel_d   = take ? (pick ? m1_sel : m0_sel) : sel_q;
        ack_d   = hit ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        err_d   = tmo ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        rd0_d   = (hit & ~owner_q) ? wb_dat_i : '0;
        rd1_d   = (hit & owner_q) ? wb_dat_i : '0;
        cyc_d   = state_d != IDLE;
        stb_d   = state_d == BUS;
        grant_d = cyc_d ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    end

    // State and registered outputs; reset aborts any beat in flight without a response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            timer_q <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            grant_q <= grant_d;
        end
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = stb_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_sel_o = sel_q;
    assign grant_o  = grant_q;
    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
    assign m0_rdata = rd0_q;
    assign m1_rdata = rd1_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized scoreboard bench for mem_bus_arbiter with an address-driven slave model
module tb_mem_bus_arbiter;
    localparam int TMO = 4;

    logic        clk = 0, rst = 1;
    logic        m0_req = 0, m0_lock = 0, m0_we = 0, m1_req = 0, m1_lock = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [3:0]  m0_sel = 0, m1_sel = 0;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i = 0;
    logic [1:0]  grant_o;

    typedef struct {logic [31:0] a; logic [31:0] d; logic we; logic [3:0] s;} bx_t;
    typedef struct {logic err; logic [31:0] rd;} rx_t;
    bx_t bq0[$], bq1[$];
    rx_t rq0[$], rq1[$];
    int tests = 0, fails = 0;

    // Slave behaviour is a pure function of the address: ack on stb cycle index dly, or never for dly >= TMO
    function automatic int dly_of(logic [31:0] a);
        return a[9] ? 5 : int'(a[5:4]);
    endfunction

    function automatic logic [31:0] rd_of(logic [31:0] a);
        return (a == 32'h8000_0010) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B9) ^ 32'h1234_5678);
    endfunction

    assign wb_dat_i = rd_of(wb_adr_o);

    mem_bus_arbiter #(.TIMEOUT(TMO), .TW(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic drv(input int p, input logic rq, input logic lk, input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input logic [3:0] s);
        if (p == 0) begin
            m0_req = rq; m0_lock = lk; m0_addr = a; m0_we = we; m0_wdata = wd; m0_sel = s;
        end else begin
            m1_req = rq; m1_lock = lk; m1_addr = a; m1_we = we; m1_wdata = wd; m1_sel = s;
        end
    endtask

    // Issue one beat, record what the bus and the requester must see, wait for the response, then release req
    task automatic beat(input int p, input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [3:0] s, input logic lk, output logic er);
        bx_t b;
        rx_t r;
        int n;
        b.a = a; b.d = wd; b.we = we; b.s = s;
        r.err = dly_of(a) >= TMO;
        r.rd  = r.err ? 32'h0 : rd_of(a);
        if (p == 0) begin bq0.push_back(b); rq0.push_back(r); end
        else begin bq1.push_back(b); rq1.push_back(r); end
        drv(p, 1'b1, lk, a, we, wd, s);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p != 0 ? (m1_ack | m1_err) : (m0_ack | m0_err)) && n < 100);
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL beat_wait p%0d: got no response expected ack or err", p);
        end
        er = (p != 0) ? m1_err : m0_err;
        @(negedge clk);
        if (p == 0) m0_req = 0; else m1_req = 0;
    endtask

    task automatic burst(input int p, input logic [31:0] base, input int n, input bit gaps);
        logic er;
        for (int k = 0; k < n; k++) begin
            beat(p, base + 32'(4 * k), 1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(0, 15)), k < n - 1, er);
            if (er) break;
            if (gaps && k < n - 1 && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        if (p == 0) m0_lock = 0; else m1_lock = 0;
    endtask

    task automatic rnd_port(input int p);
        logic [31:0] base;
        for (int i = 0; i < 50; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            base = ($urandom() & 32'hFFFF_FDF0) | (($urandom_range(0, 5) == 0) ? 32'h200 : 32'h0);
            burst(p, base, $urandom_range(1, 4), 1'b1);
        end
    endtask

    // Monitor plus slave: checks bus beats, arbitration order, latencies and responses against the queues
    int   scnt = 0, srun = 0, lrun = 0;
    logic [1:0] pg = 0, rcap = 0;
    logic pend = 0, pend_p = 0, last_m = 0, prev_err = 0;

    always @(posedge clk) rcap <= {m1_req, m0_req};

    always @(negedge clk) begin
        bx_t b;
        rx_t r;
        logic w, e;
        if (rst) begin
            scnt = 0; srun = 0; lrun = 0; pg = 0; pend = 0; last_m = 0; prev_err = 0; wb_ack_i = 0;
        end else begin
            if (wb_stb_o) srun++;
            else if (srun > 0) begin lrun = srun; srun = 0; end
            if (pend) chk("ack_latency", pend_p ? m1_ack : m0_ack, 1);
            if (prev_err) chk("release_after_err", {wb_cyc_o, grant_o}, 0);
            if (pg != 0 && grant_o != 0) chk("no_interleave", grant_o, pg);
            chk("cyc_vs_grant", wb_cyc_o, grant_o != 0);
            if (wb_stb_o && srun == 1) begin
                w = grant_o[1];
                chk("grant_onehot", grant_o == 2'b01 || grant_o == 2'b10, 1);
                if (pg == 0) begin
                    e = (rcap == 2'b11) ? ~last_m : rcap[1];
                    chk("arb_winner", w, e);
                    last_m = w;
                end else chk("hold_owner", grant_o, pg);
                if ((w ? bq1.size() : bq0.size()) == 0) begin
                    tests++; fails++;
                    $display("FAIL bus_beat: got unexpected beat on port %0d expected none", w);
                end else begin
                    b = w ? bq1.pop_front() : bq0.pop_front();
                    chk("bus_addr", wb_adr_o, b.a);
                    chk("bus_wdata", wb_dat_o, b.d);
                    chk("bus_we_sel", {wb_we_o, wb_sel_o}, {b.we, b.s});
                end
            end
            if (m0_ack | m0_err) begin
                if (rq0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL p0_resp: got spurious response expected none");
                end else begin
                    r = rq0.pop_front();
                    chk("p0_resp_kind", {m0_ack, m0_err}, r.err ? 2'b01 : 2'b10);
                    chk("p0_rdata", m0_rdata, r.rd);
                    if (m0_err) chk("p0_timeout_len", lrun, TMO);
                end
            end
            if (m1_ack | m1_err) begin
                if (rq1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL p1_resp: got spurious response expected none");
                end else begin
                    r = rq1.pop_front();
                    chk("p1_resp_kind", {m1_ack, m1_err}, r.err ? 2'b01 : 2'b10);
                    chk("p1_rdata", m1_rdata, r.rd);
                    if (m1_err) chk("p1_timeout_len", lrun, TMO);
                end
            end
            prev_err = m0_err | m1_err;
            if (wb_stb_o) begin
                wb_ack_i = (scnt == dly_of(wb_adr_o));
                scnt++;
            end else begin
                scnt = 0;
                wb_ack_i = ($urandom_range(0, 5) == 0);
            end
            pend   = wb_stb_o && wb_ack_i;
            pend_p = grant_o[1];
            pg     = grant_o;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic er0, er1;
        bx_t b;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, grant_o, m0_ack, m0_err, m1_ack, m1_err, wb_adr_o}, 0);
        chk("reset_rdata", {m0_rdata, m1_rdata}, 0);
        rst = 0;
        @(negedge clk);
        fork
            beat(0, 32'h8000_0010, 1'b0, 32'h0, 4'hF, 1'b0, er0);
            begin
                @(negedge clk);
                chk("stb_after_req", {wb_stb_o, grant_o, wb_adr_o}, {1'b1, 2'b01, 32'h8000_0010});
            end
        join
        chk("idle_after_single", grant_o, 2'b00);
        fork
            beat(0, 32'h0000_1000, 1'b0, 32'h0, 4'hF, 1'b0, er0);
            beat(1, 32'h0000_2000, 1'b0, 32'h0, 4'hF, 1'b0, er1);
            begin @(negedge clk); chk("tie1_first", grant_o, 2'b10); end
        join
        fork
            beat(0, 32'h0000_1010, 1'b1, 32'h1111_2222, 4'h3, 1'b0, er0);
            beat(1, 32'h0000_2010, 1'b0, 32'h0, 4'hF, 1'b0, er1);
            begin @(negedge clk); chk("tie3_first", grant_o, 2'b10); end
        join
        fork
            burst(1, 32'h0000_0100, 4, 1'b0);
            begin @(negedge clk); beat(0, 32'h0000_0040, 1'b0, 32'h0, 4'hF, 1'b0, er0); end
        join
        burst(1, 32'h0000_0200, 2, 1'b0);
        beat(0, 32'h0000_0030, 1'b1, 32'h00AB_0000, 4'b0100, 1'b0, er0);
        chk("ack_wins_tie", er0, 0);
        fork
            rnd_port(0);
            rnd_port(1);
        join
        @(negedge clk);
        b.a = 32'h200; b.d = 0; b.we = 0; b.s = 4'hF;
        bq0.push_back(b);
        drv(0, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 4'hF);
        repeat (2) @(negedge clk);
        #2 rst = 1;
        #1 chk("reset_aborts", {wb_cyc_o, wb_stb_o, grant_o, m0_ack, m0_err, m1_ack, m1_err}, 0);
        drv(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        fork
            beat(0, 32'h0000_3000, 1'b0, 32'h0, 4'hF, 1'b0, er0);
            beat(1, 32'h0000_4000, 1'b0, 32'h0, 4'hF, 1'b0, er1);
            begin @(negedge clk); chk("tie_after_reset", grant_o, 2'b10); end
        join
        repeat (3) @(negedge clk);
        chk("queues_drained", bq0.size() + bq1.size() + rq0.size() + rq1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external Wishbone master port between the instruction-cache refill path (port 0) and the data-cache refill/writeback path (port 1).
- Arbitrates two-way round-robin and registers each transaction.
- Supports locked multi-beat ownership so a cache-line burst is not interleaved with the other port.
- Watchdog timer converts a missing slave acknowledge into an error response.
- Sits between the two caches and the top-level bus interface.

Parameters:
- TIMEOUT, 255: max cycles in BUS waiting for wb_ack_i before an error response; 0 disables the watchdog.
- TW, 8: timer width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_req  in  1  port 0 request (held until m0_ack/m0_err)
- m0_lock  in  1  port 0 wants to keep ownership after this beat
- m0_addr  in  32  port 0 byte address
- m0_wdata  in  32  port 0 write data
- m0_we  in  1  port 0 write enable
- m0_sel  in  4  port 0 byte enables
- m0_ack  out  1  port 0 beat done, one-cycle pulse
- m0_err  out  1  port 0 beat timed out, one-cycle pulse
- m0_rdata  out  32  port 0 read data, valid with m0_ack
- m1_req, m1_lock, m1_addr, m1_wdata, m1_we, m1_sel, m1_ack, m1_err, m1_rdata: same as port 0, for port 1
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  bus strobe
- wb_adr_o  out  32  bus address
- wb_dat_o  out  32  bus write data
- wb_we_o  out  1  bus write enable
- wb_sel_o  out  4  bus byte enables
- wb_ack_i  in  1  bus acknowledge
- wb_dat_i  in  32  bus read data
- grant_o  out  2  one-hot current owner; 00 when idle

Behaviour:
Clocking and reset:
- One clock, clk. Reset rst is asynchronous, active-high.
- All outputs reset to 0. State = IDLE, timer = 0, last_grant = 0.
- Reset asserted mid-transaction aborts it: cyc/stb drop immediately and no ack or err is issued.

Registered outputs:
- wb_* outputs are driven from registers latched at grant; no combinational path from mX_* to wb_*.
- mX_ack, mX_err and mX_rdata are registered.

States: IDLE, BUS, RESP, HOLD.

IDLE:
- cyc=0, stb=0, grant_o=00.
- If exactly one req is high, grant it.
- If both are high, grant the port != last_grant. After reset this is port 1.
- On grant: latch addr/wdata/we/sel, set owner and last_grant=owner, clear timer, go to BUS.

BUS:
- cyc=1, stb=1, grant_o=onehot(owner).
- wb_ack_i=1: latch wb_dat_i, go to RESP(ack).
- Otherwise, if TIMEOUT!=0 and timer==TIMEOUT-1, go to RESP(err). Otherwise increment timer.
- Ack and timeout in the same cycle: ack wins.

RESP (1 cycle):
- stb=0, cyc=1.
- Owner's mX_ack=1 with rdata, or mX_err=1 with rdata=0. The other port's outputs stay 0.
- Next state is HOLD if the owner's lock=1 and this was an ack; otherwise IDLE, with cyc low from the next cycle.

HOLD:
- cyc=1, stb=0. The other port is not granted.
- If owner req=1: latch the new beat, clear timer, go to BUS.
- Else if owner lock=0: go to IDLE.
- Otherwise stay.

Latency:
- req sampled in IDLE/HOLD at cycle N gives stb in N+1.
- wb_ack_i at cycle K gives mX_ack at K+1.
- Minimum 3 cycles per beat.
- A requester sees ack, then drops or updates req in the following cycle. Arbiter does not sample req in RESP.

Boundary rules:
- wb_ack_i outside BUS is ignored.
- Error always releases ownership.
- Requester dropping req while in BUS has no effect: the beat completes.
- Locked owner can starve the other port; caches must bound burst length.

Test Plan:
- Single read, port 0 only: addr 0x8000_0010, slave acks 2 cycles after stb. Expect wb_adr_o=0x8000_0010 one cycle after req, m0_ack pulse with m0_rdata=0xDEADBEEF one cycle after wb_ack_i, grant_o 01 then 00.
- Tie: m0_req and m1_req rise together after reset. Port 1 is served first (grant_o=10), then port 0. Third simultaneous tie goes to port 1 again.
- Locked 4-beat burst on port 1 (addrs 0x100, 0x104, 0x108, 0x10C) with m0_req held high throughout. wb_cyc_o stays 1 across all beats, port 0 is not granted until m1_lock drops, then port 0 is served.
- Watchdog with TIMEOUT=4 and slave never acks. m1_err pulses after 4 stb cycles, m1_rdata=0, cyc drops, m1_lock ignored.
- Write: m0_we=1, sel=0100, wdata=0x00AB0000. Bus sees the same values; ack and timeout hitting in the same cycle yields ack, not err.
- Reset asserted in BUS: wb_cyc_o/stb and all acks go to 0 immediately. Arbiter restarts in IDLE, last_grant=0.
